// File: rtl/axi_lite_master_if.sv
// Single-outstanding AXI4-Lite master: turns one core request into an AW/W/B or AR/R
// transaction and returns a one-cycle completion pulse, with a response-wait timeout.
module axi_lite_master_if #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  // core request / response
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [DATA_W-1:0] ReqWData,
  input  logic [3:0]        ReqStrb,
  output logic              RspValid,
  output logic [DATA_W-1:0] RspRData,
  output logic [2:0]        RspResp,
  output logic              RspTimeout,
  // AXI-Lite master channels
  output logic              AWVALID,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [2:0]        AWPROT,
  input  logic              AWREADY,
  output logic              WVALID,
  output logic [DATA_W-1:0] WDATA,
  output logic [3:0]        WSTRB,
  input  logic              WREADY,
  input  logic              BVALID,
  input  logic [2:0]        BRESP,
  output logic              BREADY,
  output logic              ARVALID,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [2:0]        ARPROT,
  input  logic              ARREADY,
  input  logic              RVALID,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [2:0]        RRESP,
  output logic              RREADY
);

  typedef enum logic [2:0] {StIdle, StWrReq, StWrResp, StRdReq, StRdData, StDone} state_e;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          strb_q, strb_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [7:0]          wait_q, wait_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [2:0]          resp_q, resp_d;
  logic                tmo_q, tmo_d;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      wait_q    <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      tmo_q     <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      wait_q    <= wait_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    wait_d    = wait_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    tmo_d     = tmo_q;
    case (state_q)
      StIdle: begin
        if (ReqValid) begin
          addr_d    = ReqAddr;
          wdata_d   = ReqWData;
          strb_d    = ReqStrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          tmo_d     = 1'b0;
          state_d   = ReqWrite ? StWrReq : StRdReq;
        end
      end
      StWrReq: begin
        if (AWVALID && AWREADY) aw_done_d = 1'b1;
        if (WVALID && WREADY)   w_done_d  = 1'b1;
        if ((aw_done_q || AWREADY) && (w_done_q || WREADY)) begin
          wait_d  = '0;
          state_d = StWrResp;
        end
      end
      StWrResp: begin
        // A response landing on the timeout cycle still counts as a normal completion.
        if (BVALID) begin
          resp_d  = BRESP;
          rdata_d = '0;
          state_d = StDone;
        end else if ((wait_q + 8'd1) == TimeoutCnt) begin
          tmo_d   = 1'b1;
          resp_d  = 3'b111;
          rdata_d = '0;
          state_d = StDone;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StRdReq: begin
        if (ARREADY) begin
          wait_d  = '0;
          state_d = StRdData;
        end
      end
      StRdData: begin
        if (RVALID) begin
          resp_d  = RRESP;
          rdata_d = RDATA;
          state_d = StDone;
        end else if ((wait_q + 8'd1) == TimeoutCnt) begin
          tmo_d   = 1'b1;
          resp_d  = 3'b111;
          rdata_d = '0;
          state_d = StDone;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ReqReady   = (state_q == StIdle);
    AWVALID    = (state_q == StWrReq) && !aw_done_q;
    WVALID     = (state_q == StWrReq) && !w_done_q;
    BREADY     = (state_q == StWrResp);
    ARVALID    = (state_q == StRdReq);
    RREADY     = (state_q == StRdData);
    AWADDR     = AWVALID ? addr_q : '0;
    WDATA      = WVALID ? wdata_q : '0;
    WSTRB      = WVALID ? strb_q : '0;
    ARADDR     = ARVALID ? addr_q : '0;
    AWPROT     = 3'b000;
    ARPROT     = 3'b000;
    RspValid   = (state_q == StDone);
    RspRData   = RspValid ? rdata_q : '0;
    RspResp    = RspValid ? resp_q : '0;
    RspTimeout = RspValid && tmo_q;
  end

endmodule
